// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the execute-control stage and the ALU it drives:
// opcode and one-hot operation codes, FSM encoding and instruction field layout.
package alu_sequencer_pkg;

  localparam int SEQ_DATA_W   = 16;
  localparam int SEQ_NUM_REGS = 8;
  localparam int OPC_W        = 3;
  localparam int OPER_W       = 8;

  localparam logic [OPC_W-1:0] OPC_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OPC_AND = 3'd1;
  localparam logic [OPC_W-1:0] OPC_OR  = 3'd2;
  localparam logic [OPC_W-1:0] OPC_NOT = 3'd3;
  localparam logic [OPC_W-1:0] OPC_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OPC_SL  = 3'd5;
  localparam logic [OPC_W-1:0] OPC_SR  = 3'd6;
  localparam logic [OPC_W-1:0] OPC_CMP = 3'd7;

  localparam logic [OPER_W-1:0] ALU_OP_NONE = 8'h00;
  localparam logic [OPER_W-1:0] ALU_OP_ADD  = 8'h01;
  localparam logic [OPER_W-1:0] ALU_OP_AND  = 8'h02;
  localparam logic [OPER_W-1:0] ALU_OP_OR   = 8'h04;
  localparam logic [OPER_W-1:0] ALU_OP_NOT  = 8'h08;
  localparam logic [OPER_W-1:0] ALU_OP_XOR  = 8'h10;
  localparam logic [OPER_W-1:0] ALU_OP_SL   = 8'h20;
  localparam logic [OPER_W-1:0] ALU_OP_SR   = 8'h40;
  localparam logic [OPER_W-1:0] ALU_OP_CMP  = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  // Instruction layout: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb.
  localparam int INSTR_OPC_LSB = 13;
  localparam int INSTR_RD_LSB  = 10;
  localparam int INSTR_RA_LSB  = 7;
  localparam int INSTR_RB_LSB  = 4;

  localparam logic [SEQ_DATA_W-1:0] RESULT_TRUE  = 16'h0001;
  localparam logic [SEQ_DATA_W-1:0] RESULT_FALSE = 16'h0000;

  function automatic logic [OPER_W-1:0] opcode_to_onehot(input logic [OPC_W-1:0] opc);
    logic [OPER_W-1:0] onehot;
    case (opc)
      OPC_ADD: onehot = ALU_OP_ADD;
      OPC_AND: onehot = ALU_OP_AND;
      OPC_OR:  onehot = ALU_OP_OR;
      OPC_NOT: onehot = ALU_OP_NOT;
      OPC_XOR: onehot = ALU_OP_XOR;
      OPC_SL:  onehot = ALU_OP_SL;
      OPC_SR:  onehot = ALU_OP_SR;
      default: onehot = ALU_OP_CMP;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/ember_regfile.sv
// Register file with r0 hard-wired to zero, one write port (writeback beats host)
// and three combinational read ports that return the pre-write value.
module ember_regfile
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W   = SEQ_DATA_W,
  parameter int NUM_REGS = SEQ_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_host_en,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data,
  input  logic [ADDR_W-1:0] i_rd_addr_a,
  output logic [DATA_W-1:0] o_rd_data_a,
  input  logic [ADDR_W-1:0] i_rd_addr_b,
  output logic [DATA_W-1:0] o_rd_data_b,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Entry 0 is held at zero, so reads never need an address-zero special case.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_srst || i == 0) begin
        r_regs[i] <= '0;
      end else if (i_wb_en && i_wb_addr == ADDR_W'(i)) begin
        r_regs[i] <= i_wb_data;
      end else if (i_host_en && i_host_addr == ADDR_W'(i)) begin
        r_regs[i] <= i_host_data;
      end
    end
  end

  assign o_rd_data_a = r_regs[i_rd_addr_a];
  assign o_rd_data_b = r_regs[i_rd_addr_b];
  assign o_dbg_data  = r_regs[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// Execute-control stage: accepts one register-register instruction per three
// cycles, drives the combinational ALU, and writes its result back.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int DATA_W   = SEQ_DATA_W,
  parameter int NUM_REGS = SEQ_NUM_REGS
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic [15:0]                 iInstr,
  input  logic                        iInstrValid,
  output logic                        oInstrReady,
  output logic [DATA_W-1:0]           oOperandA,
  output logic [DATA_W-1:0]           oOperandB,
  output logic [OPER_W-1:0]           oOperation,
  input  logic [DATA_W-1:0]           iAluResult,
  input  logic                        iWrEn,
  input  logic [$clog2(NUM_REGS)-1:0] iWrAddr,
  input  logic [DATA_W-1:0]           iWrData,
  input  logic [$clog2(NUM_REGS)-1:0] iDbgAddr,
  output logic [DATA_W-1:0]           oDbgData,
  output logic                        oResultValid,
  output logic [DATA_W-1:0]           oResult,
  output logic [$clog2(NUM_REGS)-1:0] oResultDest
);

  localparam int ADDR_W = $clog2(NUM_REGS);

  state_t              r_state;
  state_t              w_state_next;
  logic [OPC_W-1:0]    r_opcode;
  logic [ADDR_W-1:0]   r_rd;
  logic [ADDR_W-1:0]   r_dest_hold;
  logic [DATA_W-1:0]   r_operand_a;
  logic [DATA_W-1:0]   r_operand_b;
  logic [DATA_W-1:0]   r_result;
  logic [DATA_W-1:0]   r_result_hold;

  logic                w_accept;
  logic                w_wb_en;
  logic [OPC_W-1:0]    w_opcode;
  logic [ADDR_W-1:0]   w_rd;
  logic [ADDR_W-1:0]   w_ra;
  logic [ADDR_W-1:0]   w_rb;
  logic [DATA_W-1:0]   w_ra_data;
  logic [DATA_W-1:0]   w_rb_data;
  logic                w_unused_instr;

  assign w_opcode       = iInstr[INSTR_OPC_LSB +: OPC_W];
  assign w_rd           = iInstr[INSTR_RD_LSB +: ADDR_W];
  assign w_ra           = iInstr[INSTR_RA_LSB +: ADDR_W];
  assign w_rb           = iInstr[INSTR_RB_LSB +: ADDR_W];
  assign w_unused_instr = ^iInstr[3:0];
  assign w_accept       = (r_state == ST_IDLE) && iInstrValid;

  ember_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .i_clk       (iClock),
    .i_srst      (iReset),
    .i_wb_en     (w_wb_en),
    .i_wb_addr   (r_rd),
    .i_wb_data   (r_result),
    .i_host_en   (iWrEn),
    .i_host_addr (iWrAddr),
    .i_host_data (iWrData),
    .i_rd_addr_a (w_ra),
    .o_rd_data_a (w_ra_data),
    .i_rd_addr_b (w_rb),
    .o_rd_data_b (w_rb_data),
    .i_dbg_addr  (iDbgAddr),
    .o_dbg_data  (oDbgData)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_opcode      <= '0;
      r_rd          <= '0;
      r_operand_a   <= '0;
      r_operand_b   <= '0;
      r_result      <= '0;
      r_result_hold <= '0;
      r_dest_hold   <= '0;
    end else begin
      if (w_accept) begin
        r_opcode    <= w_opcode;
        r_rd        <= w_rd;
        r_operand_a <= w_ra_data;
        r_operand_b <= w_rb_data;
      end
      if (r_state == ST_EXEC) begin
        r_result <= iAluResult;
      end
      // The hold copies keep oResult/oResultDest stable while the next
      // instruction's result is being captured.
      if (r_state == ST_WB) begin
        r_result_hold <= r_result;
        r_dest_hold   <= r_rd;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    oInstrReady  = 1'b0;
    oOperation   = ALU_OP_NONE;
    oResultValid = 1'b0;
    oResult      = r_result_hold;
    oResultDest  = r_dest_hold;
    w_wb_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        oInstrReady = 1'b1;
        if (iInstrValid) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        oOperation   = opcode_to_onehot(r_opcode);
        w_state_next = ST_WB;
      end
      ST_WB: begin
        oResultValid = 1'b1;
        oResult      = r_result;
        oResultDest  = r_rd;
        w_wb_en      = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign oOperandA = r_operand_a;
  assign oOperandB = r_operand_b;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Execute-control stage directly upstream of the combinational ALU.
- Accepts 16-bit register-register instructions over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand and one-hot operation inputs, captures the ALU result, and writes it back.
- Also exposes a host write port and a debug read port for loading and inspecting registers.

Parameters:
- DATA_W, 16, operand/result/register width (must match ALU width).
- NUM_REGS, 8, register count; address width is log2(NUM_REGS) = 3.

Ports:
- iClock  input  1  system clock; all state updates on posedge.
- iReset  input  1  synchronous, active-high reset.
- iInstr  input  16  instruction: [15:13] opcode, [12:10] rd, [9:7] ra, [6:4] rb, [3:0] ignored.
- iInstrValid  input  1  iInstr is valid this cycle.
- oInstrReady  output  1  stage can accept an instruction this cycle.
- oOperandA  output  16  to ALU iOperandA.
- oOperandB  output  16  to ALU iOperandB.
- oOperation  output  8  to ALU iOperation; one-hot, 8'h00 when not executing.
- iAluResult  input  16  from ALU oAluResult (combinational).
- iWrEn  input  1  host register write enable.
- iWrAddr  input  3  host write address.
- iWrData  input  16  host write data.
- iDbgAddr  input  3  debug read address.
- oDbgData  output  16  combinational read of register iDbgAddr.
- oResultValid  output  1  one-cycle pulse: writeback occurring this cycle.
- oResult  output  16  written-back value; held until the next writeback.
- oResultDest  output  3  destination register of that writeback.

Behaviour:
- Opcode to one-hot map: 0 ADD 8'h01, 1 AND 8'h02, 2 OR 8'h04, 3 NOT 8'h08, 4 XOR 8'h10, 5 SL 8'h20, 6 SR 8'h40, 7 CMP 8'h80.
- FSM states: IDLE, EXEC, WB. Throughput is one instruction per 3 cycles. No pipelining.
- IDLE:
  - oInstrReady=1.
  - On iInstrValid, latch opcode and rd, and latch reg[ra]/reg[rb] into the operand registers, then go to EXEC.
  - Otherwise stay in IDLE.
- EXEC:
  - oInstrReady=0; oOperation = one-hot of the latched opcode; oOperandA/B driven from the operand registers.
  - iAluResult is captured into the result register; go to WB.
- WB:
  - oInstrReady=0, oResultValid=1, oResult=captured value, oResultDest=rd.
  - reg[rd] is written at the end of the cycle; go to IDLE.
- Outside EXEC, oOperation=8'h00. Operands keep their last latched values.
- Handshake: a transfer occurs only when iInstrValid and oInstrReady are both high. iInstr is ignored in EXEC and WB, so an instruction held valid is accepted exactly once, in the next IDLE cycle.
- Latency: accept in cycle N means oResultValid in cycle N+2, and the register is updated from cycle N+3.
- No RAW hazard: writeback completes before the next accept can read the register file.
- Register r0 always reads 0; writes to r0 (host or WB) are discarded. oResultValid/oResult/oResultDest still report a WB to r0 normally.
- Simultaneous writes:
  - Host write and WB write to the same register in the same cycle: WB wins.
  - Different registers: both writes take effect.
- Read-during-write: an operand read in the accept cycle sees the pre-write value if a host write targets the same register in that cycle. The same applies to oDbgData.
- Arithmetic: all widths are DATA_W. The stage does no arithmetic; shift amounts pass the full 16-bit rb value unchanged.
- Reset (any state, including mid-EXEC/WB):
  - State goes to IDLE; all registers, the operand registers and the result register go to 0.
  - Outputs after reset: oInstrReady=1, oResultValid=0, oResult=0, oResultDest=0, oOperation=8'h00, oOperandA/B=0.
  - An in-flight instruction is dropped with no writeback.

Decomposition:
- Shared package holds:
  - opcode constants (3-bit);
  - ALU one-hot operation codes (the single definition used by both this stage and the ALU);
  - FSM state encoding;
  - instruction field bit positions;
  - TRUE/FALSE result constants.
- One sub-module: ember_regfile — 8x16 storage, r0 tied to zero, one synchronous write port with priority mux (WB over host), three combinational read ports (ra, rb, debug).

Test Plan:
- Host writes r1=5, r2=7; send 0x0CA0 (ADD r3=r1+r2) -> accepted, oOperation=8'h01 in EXEC, oResultValid pulse 2 cycles after accept with oResult=12 and oResultDest=3; oDbgData(r3)=12 afterwards.
- Send 0xF090 (CMP r4=r1==r1) -> oOperation=8'h80, result 0x0001 in r4. Repeat with ra=r1, rb=r2 -> 0x0000.
- Hold iInstrValid high continuously with two different instructions -> oInstrReady low in EXEC/WB, each instruction accepted once, results 3 cycles apart.
- Send 0x00A0 (ADD rd=r0) -> oResult=12 with oResultValid pulse, oResultDest=0; oDbgData(r0) still 0.
- Host write r3=0x1111 in the WB cycle of an ADD to r3 -> r3=12. Host write to r5 in the same cycle -> r5=0x1111.
- Assert iReset during EXEC -> next cycle IDLE, oInstrReady=1, no oResultValid pulse, all registers read 0.
